micro_seq_unit: RTL and testbench

//  Parametrised micro-program sequencer for the microprogrammed controller.

---
 rtl/micro_seq_unit.sv | 126 ++++++++++++
 tb/tb_micro_seq_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/micro_seq_unit.sv
// Micro-program sequencer: owns the micro-PC and a small return-address stack,
// and selects the next micro-address from increment, jump, branch, dispatch or call/return.
module micro_seq_unit #(
  parameter int                ADDR_W      = 6,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
  localparam int               DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [2:0]         seq_op,
  input  logic               cond,
  input  logic [ADDR_W-1:0]  target_addr,
  input  logic [ADDR_W-1:0]  dispatch_addr,
  output logic [ADDR_W-1:0]  mpc,
  output logic [ADDR_W-1:0]  mpc_inc,
  output logic [DEPTH_W-1:0] stack_depth,
  output logic               stack_full,
  output logic               stack_empty,
  output logic               seq_err
);

  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_NEXT     = 3'd0,
    OP_JUMP     = 3'd1,
    OP_CBR      = 3'd2,
    OP_DISPATCH = 3'd3,
    OP_CALL     = 3'd4,
    OP_RET      = 3'd5,
    OP_RESTART  = 3'd6,
    OP_RSVD     = 3'd7
  } seq_op_e;

  seq_op_e             op;
  logic [ADDR_W-1:0]   mpc_q;
  logic [ADDR_W-1:0]   mpc_d;
  logic [DEPTH_W-1:0]  depth_q;
  logic [DEPTH_W-1:0]  depth_d;
  logic [DEPTH_W-1:0]  depth_m1;
  logic                err_q;
  logic                err_set;
  logic                push_en;
  logic [PTR_W-1:0]    push_idx;
  logic [PTR_W-1:0]    top_idx;
  logic [ADDR_W-1:0]   top_addr;
  logic                full;
  logic                empty;
  logic [ADDR_W-1:0]   stack_mem [STACK_DEPTH];

  assign op       = seq_op_e'(seq_op);
  assign mpc_inc  = mpc_q + ADDR_W'(1);
  assign full     = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty    = (depth_q == '0);
  assign depth_m1 = depth_q - DEPTH_W'(1);
  // Entries occupy slots 0..depth-1, so the next free slot is indexed by depth itself.
  assign push_idx = depth_q[PTR_W-1:0];
  assign top_idx  = depth_m1[PTR_W-1:0];
  assign top_addr = stack_mem[top_idx];

  always_comb begin
    mpc_d   = mpc_inc;
    depth_d = depth_q;
    push_en = 1'b0;
    err_set = 1'b0;
    unique case (op)
      OP_NEXT:     mpc_d = mpc_inc;
      OP_JUMP:     mpc_d = target_addr;
      OP_CBR:      mpc_d = cond ? target_addr : mpc_inc;
      OP_DISPATCH: mpc_d = dispatch_addr;
      OP_CALL: begin
        if (full) begin
          mpc_d   = mpc_inc;
          err_set = 1'b1;
        end else begin
          mpc_d   = target_addr;
          push_en = 1'b1;
          depth_d = depth_q + DEPTH_W'(1);
        end
      end
      OP_RET: begin
        if (empty) begin
          mpc_d   = RESET_ADDR;
          err_set = 1'b1;
        end else begin
          mpc_d   = top_addr;
          depth_d = depth_m1;
        end
      end
      OP_RESTART: begin
        mpc_d   = RESET_ADDR;
        depth_d = '0;
      end
      OP_RSVD:     mpc_d = mpc_inc;
      default:     mpc_d = mpc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mpc_q   <= RESET_ADDR;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else if (!stall) begin
      mpc_q   <= mpc_d;
      depth_q <= depth_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  // Stack contents are don't-care after reset; only the depth counter is reset.
  always_ff @(posedge clk) begin
    if (!rst && !stall && push_en) begin
      stack_mem[push_idx] <= mpc_inc;
    end
  end

  assign mpc         = mpc_q;
  assign stack_depth = depth_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign seq_err     = err_q;

endmodule

// File: tb/tb_micro_seq_unit.sv
// Directed bench for micro_seq_unit: each task drives one scenario and checks
// mpc, stack depth and flags against hand-computed values.
module tb_micro_seq_unit;

  localparam int ADDR_W  = 6;
  localparam int DEPTH_W = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               stall = 1'b0;
  logic [2:0]         seq_op = 3'd0;
  logic               cond = 1'b0;
  logic [ADDR_W-1:0]  target_addr = '0;
  logic [ADDR_W-1:0]  dispatch_addr = '0;
  logic [ADDR_W-1:0]  mpc;
  logic [ADDR_W-1:0]  mpc_inc;
  logic [DEPTH_W-1:0] stack_depth;
  logic               stack_full;
  logic               stack_empty;
  logic               seq_err;

  int n_checks = 0;
  int n_pass   = 0;

  micro_seq_unit #(.ADDR_W(6), .STACK_DEPTH(4), .RESET_ADDR(6'd0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .seq_op(seq_op), .cond(cond),
    .target_addr(target_addr), .dispatch_addr(dispatch_addr),
    .mpc(mpc), .mpc_inc(mpc_inc), .stack_depth(stack_depth),
    .stack_full(stack_full), .stack_empty(stack_empty), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // Apply one operation for one clock edge, then settle 1ns past the edge.
  task automatic step(input logic [2:0] op, input logic [5:0] tgt, input logic c);
    seq_op      = op;
    target_addr = tgt;
    cond        = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(3'd0, 6'd0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] exp_mpc;
    do_reset();
    n_checks++;
    if (mpc !== 6'd0) $display("FAIL reset_mpc: got %0d expected 0", mpc); else n_pass++;
    n_checks++;
    if (stack_empty !== 1'b1 || stack_full !== 1'b0 || stack_depth !== 3'd0 || seq_err !== 1'b0)
      $display("FAIL reset_flags: empty=%0b full=%0b depth=%0d err=%0b expected 1 0 0 0",
               stack_empty, stack_full, stack_depth, seq_err);
    else n_pass++;
    n_checks++;
    if (mpc_inc !== 6'd1) $display("FAIL reset_mpc_inc: got %0d expected 1", mpc_inc); else n_pass++;
    for (int i = 1; i <= 5; i++) begin
      step(3'd0, 6'd0, 1'b0);
      exp_mpc = 6'(i);
      n_checks++;
      if (mpc !== exp_mpc) $display("FAIL next_seq: got %0d expected %0d", mpc, exp_mpc); else n_pass++;
    end
    step(3'd7, 6'd40, 1'b1);
    n_checks++;
    if (mpc !== 6'd6) $display("FAIL rsvd_as_next: got %0d expected 6", mpc); else n_pass++;
    dispatch_addr = 6'd45;
    step(3'd3, 6'd12, 1'b0);
    n_checks++;
    if (mpc !== 6'd45) $display("FAIL dispatch: got %0d expected 45", mpc); else n_pass++;
  endtask

  task automatic test_wrap_cbr();
    do_reset();
    step(3'd1, 6'd63, 1'b0);
    n_checks++;
    if (mpc_inc !== 6'd0) $display("FAIL inc_wrap: got %0d expected 0", mpc_inc); else n_pass++;
    step(3'd0, 6'd0, 1'b0);
    n_checks++;
    if (mpc !== 6'd0) $display("FAIL next_wrap: got %0d expected 0", mpc); else n_pass++;
    step(3'd2, 6'd20, 1'b0);
    n_checks++;
    if (mpc !== 6'd1) $display("FAIL cbr_not_taken: got %0d expected 1", mpc); else n_pass++;
    step(3'd2, 6'd20, 1'b1);
    n_checks++;
    if (mpc !== 6'd20) $display("FAIL cbr_taken: got %0d expected 20", mpc); else n_pass++;
    step(3'd1, 6'd63, 1'b0);
    step(3'd4, 6'd5, 1'b0);
    step(3'd5, 6'd0, 1'b0);
    n_checks++;
    if (mpc !== 6'd0 || stack_depth !== 3'd0 || seq_err !== 1'b0)
      $display("FAIL call_at_top: mpc=%0d depth=%0d err=%0b expected 0 0 0", mpc, stack_depth, seq_err);
    else n_pass++;
  endtask

  task automatic test_call_ret();
    logic [5:0] exp_mpc [4] = '{6'd30, 6'd40, 6'd31, 6'd9};
    logic [2:0] exp_dep [4] = '{3'd1, 3'd2, 3'd1, 3'd0};
    logic [2:0] ops     [4] = '{3'd4, 3'd4, 3'd5, 3'd5};
    logic [5:0] tgts    [4] = '{6'd30, 6'd40, 6'd0, 6'd0};
    do_reset();
    step(3'd1, 6'd8, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(ops[i], tgts[i], 1'b0);
      n_checks++;
      if (mpc !== exp_mpc[i] || stack_depth !== exp_dep[i])
        $display("FAIL call_ret_%0d: mpc=%0d depth=%0d expected %0d %0d",
                 i, mpc, stack_depth, exp_mpc[i], exp_dep[i]);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    logic [5:0] tgts    [4] = '{6'd20, 6'd25, 6'd30, 6'd35};
    logic [5:0] ret_mpc [4] = '{6'd31, 6'd26, 6'd21, 6'd11};
    do_reset();
    step(3'd1, 6'd10, 1'b0);
    for (int i = 0; i < 4; i++) step(3'd4, tgts[i], 1'b0);
    n_checks++;
    if (mpc !== 6'd35 || stack_depth !== 3'd4 || stack_full !== 1'b1 || seq_err !== 1'b0)
      $display("FAIL fill: mpc=%0d depth=%0d full=%0b err=%0b expected 35 4 1 0",
               mpc, stack_depth, stack_full, seq_err);
    else n_pass++;
    step(3'd4, 6'd50, 1'b0);
    n_checks++;
    if (mpc !== 6'd36 || stack_depth !== 3'd4 || stack_full !== 1'b1 || seq_err !== 1'b1)
      $display("FAIL overflow: mpc=%0d depth=%0d full=%0b err=%0b expected 36 4 1 1",
               mpc, stack_depth, stack_full, seq_err);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step(3'd5, 6'd0, 1'b0);
      n_checks++;
      if (mpc !== ret_mpc[i] || stack_depth !== 3'(3 - i))
        $display("FAIL unwind_%0d: mpc=%0d depth=%0d expected %0d %0d",
                 i, mpc, stack_depth, ret_mpc[i], 3 - i);
      else n_pass++;
    end
    n_checks++;
    if (stack_empty !== 1'b1 || stack_full !== 1'b0 || seq_err !== 1'b1)
      $display("FAIL after_unwind: empty=%0b full=%0b err=%0b expected 1 0 1",
               stack_empty, stack_full, seq_err);
    else n_pass++;
  endtask

  task automatic test_underflow();
    do_reset();
    step(3'd1, 6'd12, 1'b0);
    step(3'd5, 6'd0, 1'b0);
    n_checks++;
    if (mpc !== 6'd0 || seq_err !== 1'b1 || stack_depth !== 3'd0)
      $display("FAIL ret_empty: mpc=%0d err=%0b depth=%0d expected 0 1 0", mpc, seq_err, stack_depth);
    else n_pass++;
    step(3'd1, 6'd7, 1'b0);
    step(3'd4, 6'd22, 1'b0);
    step(3'd6, 6'd33, 1'b0);
    n_checks++;
    if (mpc !== 6'd0 || stack_depth !== 3'd0 || seq_err !== 1'b1)
      $display("FAIL restart: mpc=%0d depth=%0d err=%0b expected 0 0 1", mpc, stack_depth, seq_err);
    else n_pass++;
    do_reset();
    n_checks++;
    if (seq_err !== 1'b0) $display("FAIL err_clear: got %0b expected 0", seq_err); else n_pass++;
  endtask

  task automatic test_stall_reset();
    do_reset();
    step(3'd1, 6'd3, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(3'd1, 6'd17, 1'b0);
      n_checks++;
      if (mpc !== 6'd3) $display("FAIL stall_hold_%0d: got %0d expected 3", i, mpc); else n_pass++;
    end
    stall = 1'b0;
    step(3'd1, 6'd17, 1'b0);
    n_checks++;
    if (mpc !== 6'd17) $display("FAIL stall_release: got %0d expected 17", mpc); else n_pass++;
    step(3'd4, 6'd40, 1'b0);
    step(3'd4, 6'd50, 1'b0);
    stall = 1'b1;
    step(3'd5, 6'd0, 1'b0);
    stall = 1'b0;
    n_checks++;
    if (mpc !== 6'd50 || stack_depth !== 3'd2)
      $display("FAIL stall_ret: mpc=%0d depth=%0d expected 50 2", mpc, stack_depth);
    else n_pass++;
    stall = 1'b1;
    rst   = 1'b1;
    step(3'd4, 6'd60, 1'b0);
    rst   = 1'b0;
    stall = 1'b0;
    n_checks++;
    if (mpc !== 6'd0 || stack_depth !== 3'd0 || stack_empty !== 1'b1)
      $display("FAIL mid_chain_rst: mpc=%0d depth=%0d empty=%0b expected 0 0 1",
               mpc, stack_depth, stack_empty);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_wrap_cbr();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_stall_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
